// File: rtl/lm_div_pipe.sv
// lm_div_pipe: three-stage Mitchell logarithmic divider.
// Operands go to a 19-bit log format ({k[3:0], f[14:0]}), the logs are
// subtracted and the difference is antilog-converted to a Q16.16 quotient.
// All stages share one advance enable, so a stalled output freezes the
// whole pipe and bubbles collapse toward the output whenever out_valid = 0.
module lm_div_pipe #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] q,
  output logic           dz
);

  // Log conversion: leading-one position k, remaining bits left-aligned.
  // A zero operand maps to 0; the zero flags override the result anyway.
  function automatic logic [18:0] to_log(input logic [15:0] x);
    logic [3:0]  k;
    logic [15:0] sh;
    k = '0;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) k = i[3:0];
    end
    sh = x << (4'd15 - k);
    return {k, sh[14:0]};
  endfunction

  logic        adv;
  logic        v1, v2;
  logic [18:0] la, lb;
  logic        za1, zb1, za2, zb2;
  logic [19:0] d;
  logic [4:0]  kq;
  logic [15:0] m;
  logic [5:0]  s;
  logic [5:0]  neg_s;
  logic [31:0] q_ar;

  // A stalled, full output stage is the only thing that holds the pipe.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // S1: operand logs and special-case flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      la  <= '0;
      lb  <= '0;
      za1 <= 1'b0;
      zb1 <= 1'b0;
    end else if (adv) begin
      v1  <= in_valid & in_ready;
      la  <= to_log(a[15:0]);
      lb  <= to_log(b[15:0]);
      za1 <= (a == '0);
      zb1 <= (b == '0);
    end
  end

  // S2: 20-bit two's-complement log difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      d   <= '0;
      za2 <= 1'b0;
      zb2 <= 1'b0;
    end else if (adv) begin
      v2  <= v1;
      d   <= {1'b0, la} - {1'b0, lb};
      za2 <= za1;
      zb2 <= zb1;
    end
  end

  // Antilog: m = 1.fq scaled by 2^(kq+1) gives Q16.16; right shifts truncate.
  always_comb begin
    kq    = d[19:15];
    m     = {1'b1, d[14:0]};
    s     = {kq[4], kq} + 6'd1;
    neg_s = 6'd0 - s;
    q_ar  = '0;
    if (!s[5]) q_ar = {16'b0, m} << s[4:0];
    else       q_ar = {16'b0, m} >> neg_s[4:0];
  end

  // S3: output register; zero divisor wins over zero dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
      dz        <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      dz        <= zb2;
      if (zb2)      q <= '1;
      else if (za2) q <= '0;
      else          q <= q_ar;
    end
  end

endmodule

// File: tb/tb_lm_div_pipe.sv
// Scoreboard bench for lm_div_pipe: the driver pushes expected results as
// pairs are accepted, an independent monitor pops them on output transfers.
module tb_lm_div_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic        dz;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] eq_q[$];
  logic        eq_dz[$];
  bit          eq_lat[$];
  int          eq_cyc[$];

  logic        held = 1'b0;
  logic [31:0] hq;
  logic        hdz;
  bit          bp_done;

  // The acceptance edge is the first of the three register edges.
  localparam int LAT_EDGES = 3;

  lm_div_pipe #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model built directly from the log/antilog formulas.
  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                output logic [31:0] rq, output logic rdz);
    int ka, kb, la, lb, dd, kq, fq, m, s;
    longint r;
    rdz = 1'b0;
    if (y == 0) begin
      rq = 32'hFFFF_FFFF; rdz = 1'b1;
    end else if (x == 0) begin
      rq = 32'h0;
    end else begin
      ka = 0; kb = 0;
      for (int i = 15; i >= 0; i--) if (x[i] && ka == 0 && (x >> i) == 1) ka = i;
      for (int i = 15; i >= 0; i--) if (y[i] && kb == 0 && (y >> i) == 1) kb = i;
      la = ka * 32768 + ((int'(x) - (1 << ka)) << (15 - ka));
      lb = kb * 32768 + ((int'(y) - (1 << kb)) << (15 - kb));
      dd = la - lb;
      kq = dd >>> 15;
      fq = dd - kq * 32768;
      m  = 32768 + fq;
      s  = kq + 1;
      if (s >= 0) r = longint'(m) << s;
      else        r = longint'(m) >> (-s);
      rq = r[31:0];
    end
  endfunction

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic [31:0] exq, input logic exdz, input bit lat);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = x;
    b = y;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        eq_q.push_back(exq);
        eq_dz.push_back(exdz);
        eq_lat.push_back(lat);
        eq_cyc.push_back(cyc + 1);
        break;
      end
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
  endtask

  task automatic send_rand(input bit lat);
    logic [15:0] x, y;
    logic [31:0] rq;
    logic        rdz;
    x = 16'($urandom);
    y = 16'($urandom);
    if ($urandom_range(0, 15) == 0) y = 16'd0;
    if ($urandom_range(0, 15) == 0) x = 16'd0;
    model(x, y, rq, rdz);
    send(x, y, rq, rdz, lat);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (eq_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(eq_q.size()), 32'd0);
  endtask

  // Monitor: handshake rule, stall stability and in-order scoreboard pops.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (held && out_valid) begin
        chk("stall_q_stable", q, hq);
        chk("stall_dz_stable", 32'(dz), 32'(hdz));
      end
      if (out_valid && !out_ready) begin
        held = 1'b1; hq = q; hdz = dz;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (eq_q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          logic [31:0] xq;
          logic        xdz;
          bit          xl;
          int          xc;
          xq = eq_q.pop_front();
          xdz = eq_dz.pop_front();
          xl = eq_lat.pop_front();
          xc = eq_cyc.pop_front();
          chk("q", q, xq);
          chk("dz", 32'(dz), 32'(xdz));
          if (xl) chk("latency", 32'(cyc - xc), 32'(LAT_EDGES - 1));
        end
      end
    end
  end

  initial begin
    bit spurious;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed accuracy, extremes and special cases, back-to-back.
    send(16'd100,   16'd10,    32'h000A_8000, 1'b0, 1'b1);
    send(16'd10,    16'd100,   32'h0000_1B00, 1'b0, 1'b1);
    send(16'd7,     16'd7,     32'h0001_0000, 1'b0, 1'b1);
    send(16'd64,    16'd4,     32'h0010_0000, 1'b0, 1'b1);
    send(16'd65535, 16'd1,     32'hFFFF_0000, 1'b0, 1'b1);
    send(16'd1,     16'd65535, 32'h0000_0001, 1'b0, 1'b1);
    send(16'd5,     16'd0,     32'hFFFF_FFFF, 1'b1, 1'b1);
    send(16'd0,     16'd9,     32'h0000_0000, 1'b0, 1'b1);
    send(16'd0,     16'd0,     32'hFFFF_FFFF, 1'b1, 1'b1);
    idle();
    drain();

    // Streaming: 20 back-to-back random pairs, fixed latency means no gaps.
    for (int i = 0; i < 20; i++) send_rand(1'b1);
    idle();
    drain();

    // Random backpressure on the output.
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) send_rand(1'b0);
        idle();
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset with three results in flight behind a stalled output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = 16'(200 + i);
      b = 16'd3;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    chk("full_before_reset", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_dz", 32'(dz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    spurious = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    chk("post_rst_spurious", 32'(spurious), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
